ps2_scancode_parser: RTL and testbench



---
 rtl/ps2_scancode_parser_pkg.sv | 44 ++++
 rtl/ps2_scancode_parser_if.sv | 32 +++
 rtl/ps2_event_fifo.sv | 70 +++++++
 rtl/ps2_scancode_parser.sv | 176 +++++++++++++++++
 tb/tb_ps2_scancode_parser.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_scancode_parser_pkg.sv
// Shared PS/2 Set-2 byte constants, parser state encodings and the event layout
// used by the scan-code parser and its event FIFO.
package ps2_scancode_parser_pkg;

    localparam logic [7:0] PS2_PREFIX_E0     = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_F0     = 8'hF0;
    localparam logic [7:0] PS2_PREFIX_E1     = 8'hE1;
    localparam logic [7:0] PS2_FAKE_SHIFT_12 = 8'h12;
    localparam logic [7:0] PS2_FAKE_SHIFT_59 = 8'h59;
    localparam logic [7:0] PS2_PAUSE_CODE    = 8'h77;
    localparam logic [2:0] PS2_E1_SKIP_BYTES = 3'd7;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_GOT_E0   = 3'd1;
    localparam logic [2:0] ST_GOT_F0   = 3'd2;
    localparam logic [2:0] ST_GOT_E0F0 = 3'd3;
    localparam logic [2:0] ST_SKIP_E1  = 3'd4;

    typedef struct packed {
        logic       extended;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    localparam int PS2_EVENT_W = $bits(ps2_event_t);

    // Keyboard replies (ACK, BAT result, echo, resend, errors) that never form key events
    function automatic logic is_filtered(input logic [7:0] b);
        case (b)
            8'h00, 8'hAA, 8'hEE, 8'hFA,
            8'hFC, 8'hFD, 8'hFE, 8'hFF: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PS2_PREFIX_E0) || (b == PS2_PREFIX_F0) || (b == PS2_PREFIX_E1);
    endfunction

    function automatic logic is_fake_shift(input logic [7:0] b);
        return (b == PS2_FAKE_SHIFT_12) || (b == PS2_FAKE_SHIFT_59);
    endfunction

endpackage

// File: rtl/ps2_scancode_parser_if.sv
// Byte input from PS2_Controller plus the show-ahead key-event stream to the consumer.
interface ps2_scancode_parser_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] evt_code;
    logic       evt_extended;
    logic       evt_break;
    logic       evt_valid;
    logic       evt_ready;

    modport master (
        input  rx_data,
        input  rx_valid,
        input  evt_ready,
        output evt_code,
        output evt_extended,
        output evt_break,
        output evt_valid
    );

    modport slave (
        output rx_data,
        output rx_valid,
        output evt_ready,
        input  evt_code,
        input  evt_extended,
        input  evt_break,
        input  evt_valid
    );

endinterface

// File: rtl/ps2_event_fifo.sv
// Generic show-ahead synchronous FIFO. The head is kept in a register so it stays
// stable, including after the last pop, until a newer entry reaches the head.
module ps2_event_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_next;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO only fits because the same-cycle pop frees a slot
    assign do_push = push && (!full || do_pop);
    assign rd_next = rd_ptr + AW'(do_pop);

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + CW'(1);
        end else if (do_pop && !do_push) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // The incoming word bypasses the array when it lands in the slot that becomes the head
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            count  <= count_next;
            rd_ptr <= rd_next;
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (count_next != '0) begin
                dout <= (do_push && (wr_ptr == rd_next)) ? din : mem[rd_next];
            end
        end
    end

endmodule

// File: rtl/ps2_scancode_parser.sv
// Turns the PS2_Controller byte stream into Set-2 make/break key events, queues them
// for the consumer and tracks the held state of four configurable keys.
module ps2_scancode_parser
    import ps2_scancode_parser_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 2500000,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter logic [8:0]  KEY0_CODE      = 9'h029,
    parameter logic [8:0]  KEY1_CODE      = 9'h05A,
    parameter logic [8:0]  KEY2_CODE      = 9'h076,
    parameter logic [8:0]  KEY3_CODE      = 9'h175
) (
    input  logic                         CLOCK_50,
    input  logic                         resetn,
    ps2_scancode_parser_if.master        bus,
    output logic [3:0]                   key_held,
    output logic                         overflow,
    output logic                         proto_err
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [2:0]       skip_q;
    logic [2:0]       skip_d;
    logic [TMO_W-1:0] tmo_q;
    logic             emit;
    logic             err;
    ps2_event_t       emit_evt;
    ps2_event_t       head_evt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic [3:0]       key_hit;

    always_comb begin
        state_d           = state_q;
        skip_d            = skip_q;
        emit              = 1'b0;
        err               = 1'b0;
        emit_evt.code     = bus.rx_data;
        emit_evt.extended = 1'b0;
        emit_evt.brk      = 1'b0;
        if (bus.rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.rx_data == PS2_PREFIX_E0) begin
                        state_d = ST_GOT_E0;
                    end else if (bus.rx_data == PS2_PREFIX_F0) begin
                        state_d = ST_GOT_F0;
                    end else if (bus.rx_data == PS2_PREFIX_E1) begin
                        state_d = ST_SKIP_E1;
                        skip_d  = PS2_E1_SKIP_BYTES;
                    end else if (!is_filtered(bus.rx_data)) begin
                        emit = 1'b1;
                    end
                end
                ST_GOT_E0: begin
                    if (bus.rx_data == PS2_PREFIX_F0) begin
                        state_d = ST_GOT_E0F0;
                    end else if (bus.rx_data != PS2_PREFIX_E0) begin
                        state_d = ST_IDLE;
                        if (is_filtered(bus.rx_data)) begin
                            err = 1'b1;
                        end else if (!is_fake_shift(bus.rx_data)) begin
                            emit              = 1'b1;
                            emit_evt.extended = 1'b1;
                        end
                    end
                end
                ST_GOT_F0: begin
                    state_d = ST_IDLE;
                    if (is_filtered(bus.rx_data) || is_prefix(bus.rx_data)) begin
                        err = 1'b1;
                    end else begin
                        emit         = 1'b1;
                        emit_evt.brk = 1'b1;
                    end
                end
                ST_GOT_E0F0: begin
                    state_d = ST_IDLE;
                    if (is_filtered(bus.rx_data) || is_prefix(bus.rx_data)) begin
                        err = 1'b1;
                    end else if (!is_fake_shift(bus.rx_data)) begin
                        emit              = 1'b1;
                        emit_evt.extended = 1'b1;
                        emit_evt.brk      = 1'b1;
                    end
                end
                ST_SKIP_E1: begin
                    // The Pause sequence is reported once, when its last byte arrives
                    if (skip_q == 3'd1) begin
                        state_d           = ST_IDLE;
                        emit              = 1'b1;
                        emit_evt.code     = PS2_PAUSE_CODE;
                        emit_evt.extended = 1'b1;
                    end else begin
                        skip_d = skip_q - 3'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if ((state_q != ST_IDLE) && (tmo_q == TMO_LAST)) begin
            state_d = ST_IDLE;
            err     = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            skip_q    <= '0;
            tmo_q     <= '0;
            proto_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            skip_q    <= skip_d;
            proto_err <= err;
            if (bus.rx_valid || (state_q == ST_IDLE) || (tmo_q == TMO_LAST)) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + TMO_W'(1);
            end
        end
    end

    assign key_hit[0] = ({emit_evt.extended, emit_evt.code} == KEY0_CODE);
    assign key_hit[1] = ({emit_evt.extended, emit_evt.code} == KEY1_CODE);
    assign key_hit[2] = ({emit_evt.extended, emit_evt.code} == KEY2_CODE);
    assign key_hit[3] = ({emit_evt.extended, emit_evt.code} == KEY3_CODE);

    assign pop = !fifo_empty && bus.evt_ready;

    // Held state follows every decoded event, even one the full FIFO has to drop
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            key_held <= '0;
            overflow <= 1'b0;
        end else begin
            if (emit) begin
                for (int i = 0; i < 4; i++) begin
                    if (key_hit[i]) begin
                        key_held[i] <= !emit_evt.brk;
                    end
                end
            end
            if (emit && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    ps2_event_fifo #(
        .WIDTH (PS2_EVENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_event_fifo (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .push     (emit),
        .din      (emit_evt),
        .pop      (pop),
        .dout     (head_evt),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign bus.evt_code     = head_evt.code;
    assign bus.evt_extended = head_evt.extended;
    assign bus.evt_break    = head_evt.brk;
    assign bus.evt_valid    = !fifo_empty;

endmodule

// File: tb/tb_ps2_scancode_parser.sv
// Bench for ps2_scancode_parser: directed scan-code sequences and random byte streams
// compared each cycle against a prefix-list reference model of the Set-2 rules.
module tb_ps2_scancode_parser;

    localparam int TIMEOUT = 100;
    localparam int DEPTH   = 4;

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } evt_t;

    logic       CLOCK_50 = 1'b0;
    logic       resetn;
    logic [3:0] key_held;
    logic       overflow;
    logic       proto_err;

    ps2_scancode_parser_if bus();

    ps2_scancode_parser #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .FIFO_DEPTH     (DEPTH),
        .KEY0_CODE      (9'h029),
        .KEY1_CODE      (9'h05A),
        .KEY2_CODE      (9'h076),
        .KEY3_CODE      (9'h175)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .resetn    (resetn),
        .bus       (bus),
        .key_held  (key_held),
        .overflow  (overflow),
        .proto_err (proto_err)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int         assert_count = 0;
    int         fail_count   = 0;
    evt_t       mq[$];
    evt_t       last_head;
    logic [7:0] pend[$];
    int         skip_left;
    int         idle_cycles;
    logic [3:0] m_keys;
    logic       m_ovf;
    logic       m_err;
    logic [8:0] key_codes [4];
    logic [7:0] filt_list [8];
    logic [7:0] key_bytes [4];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic bit model_filtered(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            if (filt_list[i] == b) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        mq.delete();
        pend.delete();
        last_head   = '{8'h00, 1'b0, 1'b0};
        skip_left   = 0;
        idle_cycles = 0;
        m_keys      = 4'b0000;
        m_ovf       = 1'b0;
        m_err       = 1'b0;
    endtask

    task automatic model_emit(input logic [7:0] code, input logic ext, input logic brk);
        evt_t e;
        e = '{code, ext, brk};
        for (int i = 0; i < 4; i++) begin
            if ({ext, code} == key_codes[i]) m_keys[i] = !brk;
        end
        if (mq.size() < DEPTH) mq.push_back(e);
        else m_ovf = 1'b1;
    endtask

    // The model keeps the prefix bytes seen so far and decides once a key byte completes them
    task automatic model_byte(input logic [7:0] b);
        bit has_e0;
        bit has_f0;
        bit fake;
        fake = (b == 8'h12) || (b == 8'h59);
        if (skip_left > 0) begin
            skip_left--;
            if (skip_left == 0) model_emit(8'h77, 1'b1, 1'b0);
        end else if (pend.size() == 0) begin
            if (b == 8'hE0 || b == 8'hF0) pend.push_back(b);
            else if (b == 8'hE1) skip_left = 7;
            else if (!model_filtered(b)) model_emit(b, 1'b0, 1'b0);
        end else begin
            has_e0 = (pend[0] == 8'hE0);
            has_f0 = (pend[$] == 8'hF0);
            if (has_e0 && !has_f0) begin
                if (b == 8'hF0) pend.push_back(b);
                else if (b != 8'hE0) begin
                    pend.delete();
                    if (model_filtered(b)) m_err = 1'b1;
                    else if (!fake) model_emit(b, 1'b1, 1'b0);
                end
            end else begin
                pend.delete();
                if (has_e0 && fake) begin
                end else if (model_filtered(b) || b == 8'hE0 || b == 8'hF0 || b == 8'hE1) m_err = 1'b1;
                else model_emit(b, has_e0, 1'b1);
            end
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic ready);
        bus.rx_valid  = valid;
        bus.rx_data   = data;
        bus.evt_ready = ready;
        m_err = 1'b0;
        if (ready && mq.size() > 0) void'(mq.pop_front());
        if (valid) begin
            idle_cycles = 0;
            model_byte(data);
        end else if (pend.size() > 0 || skip_left > 0) begin
            idle_cycles++;
            if (idle_cycles == TIMEOUT) begin
                pend.delete();
                skip_left   = 0;
                idle_cycles = 0;
                m_err       = 1'b1;
            end
        end else begin
            idle_cycles = 0;
        end
        if (mq.size() > 0) last_head = mq[0];
        @(posedge CLOCK_50);
        #1;
        checkOutput("evt_valid", 32'(bus.evt_valid), 32'(mq.size() > 0));
        checkOutput("evt_code", 32'(bus.evt_code), 32'(last_head.code));
        checkOutput("evt_extended", 32'(bus.evt_extended), 32'(last_head.ext));
        checkOutput("evt_break", 32'(bus.evt_break), 32'(last_head.brk));
        checkOutput("key_held", 32'(key_held), 32'(m_keys));
        checkOutput("overflow", 32'(overflow), 32'(m_ovf));
        checkOutput("proto_err", 32'(proto_err), 32'(m_err));
    endtask

    task automatic sendByte(input logic [7:0] b);
        applyStimulus(1'b1, b, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
    endtask

    task automatic popExpect(input string tag, input logic [7:0] code, input logic ext, input logic brk);
        checkOutput({tag, "_valid"}, 32'(bus.evt_valid), 32'd1);
        checkOutput({tag, "_code"}, 32'(bus.evt_code), 32'(code));
        checkOutput({tag, "_ext"}, 32'(bus.evt_extended), 32'(ext));
        checkOutput({tag, "_brk"}, 32'(bus.evt_break), 32'(brk));
        applyStimulus(1'b0, 8'h00, 1'b1);
    endtask

    function automatic logic [7:0] random_byte();
        case ($urandom_range(0, 11))
            0, 1:    return 8'hE0;
            2, 3:    return 8'hF0;
            4:       return ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'h29;
            5:       return filt_list[$urandom_range(0, 7)];
            6:       return ($urandom_range(0, 1) == 1) ? 8'h12 : 8'h59;
            7, 8:    return key_bytes[$urandom_range(0, 3)];
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         n;
        int         gap;
        logic [7:0] b;
        logic       rdy;

        key_codes = '{9'h029, 9'h05A, 9'h076, 9'h175};
        filt_list = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
        key_bytes = '{8'h29, 8'h5A, 8'h76, 8'h75};
        model_reset();
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;
        bus.evt_ready = 1'b0;
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #3;
        checkOutput("rst_evt_valid", 32'(bus.evt_valid), 32'd0);
        checkOutput("rst_evt_code", 32'(bus.evt_code), 32'd0);
        checkOutput("rst_evt_ext", 32'(bus.evt_extended), 32'd0);
        checkOutput("rst_evt_brk", 32'(bus.evt_break), 32'd0);
        checkOutput("rst_key_held", 32'(key_held), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_proto_err", 32'(proto_err), 32'd0);
        @(posedge CLOCK_50);
        #1 resetn = 1'b1;

        $display("[TB] space make/break");
        sendByte(8'h29);
        checkOutput("space_held", 32'(key_held[0]), 32'd1);
        popExpect("space_make", 8'h29, 1'b0, 1'b0);
        sendByte(8'hF0);
        sendByte(8'h29);
        checkOutput("space_released", 32'(key_held[0]), 32'd0);
        popExpect("space_break", 8'h29, 1'b0, 1'b1);

        $display("[TB] extended up arrow and fake shift");
        sendByte(8'hE0);
        sendByte(8'h75);
        checkOutput("up_held", 32'(key_held[3]), 32'd1);
        popExpect("up_make", 8'h75, 1'b1, 1'b0);
        sendByte(8'hE0);
        sendByte(8'hF0);
        sendByte(8'h75);
        checkOutput("up_released", 32'(key_held[3]), 32'd0);
        popExpect("up_break", 8'h75, 1'b1, 1'b1);
        sendByte(8'hE0);
        sendByte(8'h12);
        sendByte(8'hE0);
        sendByte(8'h75);
        popExpect("fake_shift_up", 8'h75, 1'b1, 1'b0);
        checkOutput("fake_shift_single", 32'(bus.evt_valid), 32'd0);
        sendByte(8'hE0);
        sendByte(8'hF0);
        sendByte(8'h75);
        popExpect("up_break2", 8'h75, 1'b1, 1'b1);

        $display("[TB] pause and filtered bytes");
        foreach (key_bytes[i]) begin end
        sendByte(8'hE1); sendByte(8'h14); sendByte(8'h77); sendByte(8'hE1);
        sendByte(8'hF0); sendByte(8'h14); sendByte(8'hF0); sendByte(8'h77);
        popExpect("pause", 8'h77, 1'b1, 1'b0);
        checkOutput("pause_single", 32'(bus.evt_valid), 32'd0);
        sendByte(8'hFA);
        sendByte(8'hAA);
        checkOutput("filtered_none", 32'(bus.evt_valid), 32'd0);

        $display("[TB] push and pop while full");
        sendByte(8'h1C); sendByte(8'h32); sendByte(8'h21); sendByte(8'h23);
        applyStimulus(1'b1, 8'h2B, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("full_pushpop_ovf", 32'(overflow), 32'd0);
        popExpect("pp0", 8'h32, 1'b0, 1'b0);
        popExpect("pp1", 8'h21, 1'b0, 1'b0);
        popExpect("pp2", 8'h23, 1'b0, 1'b0);
        popExpect("pp3", 8'h2B, 1'b0, 1'b0);
        checkOutput("pp_empty", 32'(bus.evt_valid), 32'd0);
        checkOutput("pp_hold_code", 32'(bus.evt_code), 32'h2B);

        $display("[TB] overflow");
        sendByte(8'h1C); sendByte(8'h32); sendByte(8'h21); sendByte(8'h23); sendByte(8'h2B);
        checkOutput("ovf_set", 32'(overflow), 32'd1);
        popExpect("ovf0", 8'h1C, 1'b0, 1'b0);
        popExpect("ovf1", 8'h32, 1'b0, 1'b0);
        popExpect("ovf2", 8'h21, 1'b0, 1'b0);
        popExpect("ovf3", 8'h23, 1'b0, 1'b0);
        checkOutput("ovf_empty", 32'(bus.evt_valid), 32'd0);
        checkOutput("ovf_sticky", 32'(overflow), 32'd1);

        $display("[TB] timeout after F0");
        applyStimulus(1'b1, 8'hF0, 1'b0);
        n = 0;
        while (proto_err !== 1'b1 && n < TIMEOUT + 50) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
            n++;
        end
        checkOutput("timeout_cycles", 32'(n), 32'(TIMEOUT));
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("timeout_pulse_end", 32'(proto_err), 32'd0);
        sendByte(8'h1C);
        popExpect("after_timeout", 8'h1C, 1'b0, 1'b0);

        $display("[TB] reset mid-sequence");
        sendByte(8'h29);
        sendByte(8'h1C);
        applyStimulus(1'b1, 8'hE0, 1'b0);
        bus.rx_valid = 1'b0;
        resetn = 1'b0;
        #2;
        checkOutput("midrst_evt_valid", 32'(bus.evt_valid), 32'd0);
        checkOutput("midrst_key_held", 32'(key_held), 32'd0);
        checkOutput("midrst_overflow", 32'(overflow), 32'd0);
        model_reset();
        @(posedge CLOCK_50);
        #1 resetn = 1'b1;
        sendByte(8'h75);
        popExpect("after_reset", 8'h75, 1'b0, 1'b0);

        $display("[TB] random byte stream");
        for (int k = 0; k < 400; k++) begin
            b   = random_byte();
            rdy = ($urandom_range(0, 99) < 60);
            applyStimulus(1'b1, b, rdy);
            gap = ($urandom_range(0, 29) == 0) ? int'($urandom_range(TIMEOUT - 3, TIMEOUT + 3))
                                               : int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                rdy = ($urandom_range(0, 99) < 60);
                applyStimulus(1'b0, 8'($urandom), rdy);
            end
        end
        for (int k = 0; k < DEPTH + 2; k++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
